// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, DONE} state_e;

  localparam logic MODE_LOAD  = 1'b0;
  localparam logic MODE_PULSE = 1'b1;

  // Bit k is the tail value required at check phase k: the pulse, then two zeros.
  localparam logic [2:0] TAIL_EXP = 3'b001;

endpackage

// File: rtl/ccff_multi_loader_if.sv
// Bitstream source, fabric programming port and status bundle of the loader.
interface ccff_multi_loader_if #(
  parameter int NUM_CHAINS = 1,
  parameter int CNT_W      = 15
);
  logic                  start;
  logic                  mode;
  logic [NUM_CHAINS-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [NUM_CHAINS-1:0] ccff_head;
  logic                  ccff_shift_en;
  logic [NUM_CHAINS-1:0] ccff_tail;
  logic                  busy;
  logic                  done;
  logic [NUM_CHAINS-1:0] err;
  logic [CNT_W-1:0]      shift_count;

  modport slave (
    input  start, mode, s_data, s_valid, ccff_tail,
    output s_ready, ccff_head, ccff_shift_en, busy, done, err, shift_count
  );

  modport master (
    output start, mode, s_data, s_valid, ccff_tail,
    input  s_ready, ccff_head, ccff_shift_en, busy, done, err, shift_count
  );
endinterface

// File: rtl/ccff_pulse_checker.sv
// Per-chain tail compare against the expected pulse pattern, with sticky error flags.
module ccff_pulse_checker
  import ccff_loader_pkg::*;
#(
  parameter int NUM_CHAINS = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  smp_i,
  input  logic [1:0]            phase_i,
  input  logic [NUM_CHAINS-1:0] tail_i,
  output logic [NUM_CHAINS-1:0] err_o
);
  logic [NUM_CHAINS-1:0] err_q, err_d;
  logic                  exp_bit;

  assign exp_bit = TAIL_EXP[phase_i];

  always_comb begin
    err_d = err_q;
    if (clr_i)      err_d = '0;
    else if (smp_i) err_d = err_q | (tail_i ^ {NUM_CHAINS{exp_bit}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= '0;
    else        err_q <= err_d;
  end

  assign err_o = err_q;
endmodule

// File: rtl/ccff_multi_loader.sv
// Drives NUM_CHAINS configuration chains from a valid/ready bitstream (LOAD)
// or runs a single-pulse continuity self-check on every chain (PULSE).
module ccff_multi_loader
  import ccff_loader_pkg::*;
#(
  parameter int NUM_CHAINS = 1,
  parameter int CHAIN_LEN  = 29696,
  parameter int CNT_W      = $clog2(CHAIN_LEN + 3)
) (
  input logic                prog_clk,
  input logic                RSTB,
  ccff_multi_loader_if.slave bus
);
  localparam logic [CNT_W-1:0] LEN     = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LEN_M1  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CHAIN_LEN + 2);

  state_e                state_q, state_d;
  logic                  mode_q, mode_d;
  logic [NUM_CHAINS-1:0] head_q, head_d;
  logic                  sen_q, sen_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [1:0]            chk_q, chk_d;
  logic                  ready, clr, smp;
  logic [1:0]            phase;

  assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
  // Ready drops once the last beat is in, so the final shift drains before DONE.
  assign ready   = (state_q == SHIFT) && (mode_q == MODE_LOAD) && (cnt_q != LEN);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    head_d  = head_q;
    sen_d   = 1'b0;
    cnt_d   = cnt_q;
    chk_d   = chk_q;
    clr     = 1'b0;
    smp     = 1'b0;
    phase   = chk_q - 2'd1;
    unique case (state_q)
      IDLE, DONE: begin
        head_d = '0;
        if (bus.start) begin
          state_d = SHIFT;
          mode_d  = bus.mode;
          clr     = 1'b1;
          chk_d   = '0;
          cnt_d   = '0;
          // The pulse is injected on the accepting edge itself.
          if (bus.mode == MODE_PULSE) begin
            head_d = '1;
            sen_d  = 1'b1;
            cnt_d  = CNT_W'(1);
          end
        end
      end
      SHIFT: begin
        if (mode_q == MODE_PULSE) begin
          head_d = '0;
          sen_d  = 1'b1;
          cnt_d  = cnt_inc;
          if (cnt_q == LEN_M1) state_d = CHECK;
        end else if (cnt_q == LEN) begin
          head_d  = '0;
          state_d = DONE;
        end else if (bus.s_valid) begin
          head_d = bus.s_data;
          sen_d  = 1'b1;
          cnt_d  = cnt_inc;
        end
      end
      CHECK: begin
        // Phases 0/1 shift two extra zeros; the tail lags its shift edge by one cycle.
        head_d = '0;
        chk_d  = chk_q + 2'd1;
        if (chk_q < 2'd2) begin
          sen_d = 1'b1;
          cnt_d = cnt_inc;
        end
        smp = (chk_q != 2'd0);
        if (chk_q == 2'd3) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge RSTB) begin
    if (!RSTB) begin
      state_q <= IDLE;
      mode_q  <= MODE_LOAD;
      head_q  <= '0;
      sen_q   <= 1'b0;
      cnt_q   <= '0;
      chk_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      head_q  <= head_d;
      sen_q   <= sen_d;
      cnt_q   <= cnt_d;
      chk_q   <= chk_d;
    end
  end

  ccff_pulse_checker #(.NUM_CHAINS(NUM_CHAINS)) u_chk (
    .clk     (prog_clk),
    .rst_n   (RSTB),
    .clr_i   (clr),
    .smp_i   (smp),
    .phase_i (phase),
    .tail_i  (bus.ccff_tail),
    .err_o   (bus.err)
  );

  assign bus.s_ready       = ready;
  assign bus.ccff_head     = head_q;
  assign bus.ccff_shift_en = sen_q;
  assign bus.busy          = (state_q == SHIFT) || (state_q == CHECK);
  assign bus.done          = (state_q == DONE);
  assign bus.shift_count   = cnt_q;
endmodule

// File: tb/tb_ccff_multi_loader.sv
// Drives four loader instances against behavioural fabric chains attached to head/tail.
module tb_ccff_multi_loader;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  ccff_multi_loader_if #(.NUM_CHAINS(1), .CNT_W(4))  b1();
  ccff_multi_loader_if #(.NUM_CHAINS(2), .CNT_W(4))  b2();
  ccff_multi_loader_if #(.NUM_CHAINS(4), .CNT_W(5))  b4();
  ccff_multi_loader_if #(.NUM_CHAINS(1), .CNT_W(15)) bd();

  ccff_multi_loader #(.NUM_CHAINS(1), .CHAIN_LEN(8))  u1 (.prog_clk(clk), .RSTB(rst_n), .bus(b1));
  ccff_multi_loader #(.NUM_CHAINS(2), .CHAIN_LEN(8))  u2 (.prog_clk(clk), .RSTB(rst_n), .bus(b2));
  ccff_multi_loader #(.NUM_CHAINS(4), .CHAIN_LEN(16)) u4 (.prog_clk(clk), .RSTB(rst_n), .bus(b4));
  ccff_multi_loader                                   ud (.prog_clk(clk), .RSTB(rst_n), .bus(bd));

  // Fabric chains: shift on the edge where shift_en is high; chain 2 of u4 may be one FF short.
  logic [7:0]       m1 = '0;
  logic [1:0][7:0]  m2 = '0;
  logic [3:0][15:0] m4 = '0;
  logic [29695:0]   md = '0;
  logic             short2 = 1'b0;

  always @(posedge clk) begin
    if (b1.ccff_shift_en) m1 <= {m1[6:0], b1.ccff_head[0]};
    if (b2.ccff_shift_en) for (int i = 0; i < 2; i++) m2[i] <= {m2[i][6:0], b2.ccff_head[i]};
    if (b4.ccff_shift_en) for (int i = 0; i < 4; i++) m4[i] <= {m4[i][14:0], b4.ccff_head[i]};
    if (bd.ccff_shift_en) md <= {md[29694:0], bd.ccff_head[0]};
  end

  assign b1.ccff_tail = m1[7];
  assign b2.ccff_tail = {m2[1][7], m2[0][7]};
  assign b4.ccff_tail = {m4[3][15], (short2 ? m4[2][14] : m4[2][15]), m4[1][15], m4[0][15]};
  assign bd.ccff_tail = md[29695];

  // Free-running event counters; runs are measured as differences of snapshots.
  int sen1 = 0, bsy1 = 0, sen2 = 0, sen4 = 0, bsy4 = 0, bsyd = 0;
  always @(negedge clk) begin
    sen1 <= sen1 + int'(b1.ccff_shift_en);
    bsy1 <= bsy1 + int'(b1.busy);
    sen2 <= sen2 + int'(b2.ccff_shift_en);
    sen4 <= sen4 + int'(b4.ccff_shift_en);
    bsy4 <= bsy4 + int'(b4.busy);
    bsyd <= bsyd + int'(bd.busy);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tot_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic kick(input int sel, input logic m);
    @(posedge clk); #1;
    case (sel)
      1: begin b1.start = 1'b1; b1.mode = m; end
      2: begin b2.start = 1'b1; b2.mode = m; end
      4: begin b4.start = 1'b1; b4.mode = m; end
      default: begin bd.start = 1'b1; bd.mode = m; end
    endcase
    @(posedge clk); #1;
    b1.start = 1'b0; b2.start = 1'b0; b4.start = 1'b0; bd.start = 1'b0;
  endtask

  int s0, q0, k, cyc;
  logic acc;
  logic [7:0] p0, p1;

  initial begin
    b1.start = 0; b1.mode = 0; b1.s_valid = 0; b1.s_data = '0;
    b2.start = 0; b2.mode = 0; b2.s_valid = 0; b2.s_data = '0;
    b4.start = 0; b4.mode = 0; b4.s_valid = 0; b4.s_data = '0;
    bd.start = 0; bd.mode = 0; bd.s_valid = 0; bd.s_data = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_u4_outputs", {b4.ccff_head, b4.ccff_shift_en, b4.s_ready, b4.busy, b4.done, b4.err, b4.shift_count}, '0);
    chk("rst_u2_outputs", {b2.ccff_head, b2.ccff_shift_en, b2.s_ready, b2.busy, b2.done, b2.err, b2.shift_count}, '0);
    rst_n = 1'b1;

    // PULSE, 1 chain of 8
    s0 = sen1; q0 = bsy1;
    kick(1, 1'b1);
    @(negedge clk);
    chk("p8_first_shift_en", b1.ccff_shift_en, 1);
    chk("p8_first_head", b1.ccff_head, 1);
    for (int i = 0; i < 40 && !b1.done; i++) @(negedge clk);
    #1;
    chk("p8_done", b1.done, 1);
    chk("p8_busy_cycles", bsy1 - q0, 11);
    chk("p8_err", b1.err, 0);
    chk("p8_shift_count", b1.shift_count, 10);
    chk("p8_shift_pulses", sen1 - s0, 10);

    // PULSE, 4 chains of 16 with chain 2 one FF short
    short2 = 1'b1; q0 = bsy4;
    kick(4, 1'b1);
    for (int i = 0; i < 60 && !b4.done; i++) @(negedge clk);
    #1;
    chk("short_done", b4.done, 1);
    chk("short_err", b4.err, 4'b0100);
    chk("short_busy_cycles", bsy4 - q0, 19);
    chk("short_shift_count", b4.shift_count, 18);
    chk("done_idle_outputs", {b4.ccff_head, b4.ccff_shift_en}, 0);

    // start in DONE clears err; start while busy is ignored
    short2 = 1'b0; s0 = sen4; q0 = bsy4;
    kick(4, 1'b1);
    @(negedge clk);
    chk("restart_err_clr", b4.err, 0);
    chk("restart_busy", {b4.busy, b4.done}, 2'b10);
    repeat (4) @(posedge clk);
    #1 b4.start = 1'b1; b4.mode = 1'b0;
    @(posedge clk);
    #1 b4.start = 1'b0;
    for (int i = 0; i < 60 && !b4.done; i++) @(negedge clk);
    #1;
    chk("busy_start_done", b4.done, 1);
    chk("busy_start_cycles", bsy4 - q0, 19);
    chk("busy_start_pulses", sen4 - s0, 18);
    chk("busy_start_err", b4.err, 0);

    // asynchronous reset during shift 5, then a clean rerun
    kick(4, 1'b1);
    for (int i = 0; i < 40 && b4.shift_count != 5; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_outputs", {b4.ccff_head, b4.ccff_shift_en, b4.s_ready, b4.busy, b4.done, b4.err, b4.shift_count}, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    q0 = bsy4;
    kick(4, 1'b1);
    for (int i = 0; i < 60 && !b4.done; i++) @(negedge clk);
    #1;
    chk("rerun_done", b4.done, 1);
    chk("rerun_err", b4.err, 0);
    chk("rerun_busy_cycles", bsy4 - q0, 19);

    // LOAD, 2 chains of 8, random stalls
    p0 = 8'hA5; p1 = 8'h3C; s0 = sen2;
    kick(2, 1'b0);
    k = 0; cyc = 0;
    while (k < 8 && cyc < 300) begin
      b2.s_valid = ($urandom_range(99) >= 30);
      b2.s_data  = {p1[7-k], p0[7-k]};
      @(negedge clk);
      acc = b2.s_valid && b2.s_ready;
      @(posedge clk); #1;
      if (acc) k++;
      cyc++;
    end
    b2.s_valid = 1'b0;
    chk("load_beats_taken", k, 8);
    for (int i = 0; i < 20 && !b2.done; i++) @(negedge clk);
    #1;
    chk("load_done", b2.done, 1);
    chk("load_chain0", m2[0], 8'hA5);
    chk("load_chain1", m2[1], 8'h3C);
    chk("load_shift_pulses", sen2 - s0, 8);
    chk("load_shift_count", b2.shift_count, 8);
    chk("load_err", b2.err, 0);
    chk("load_ready_in_done", b2.s_ready, 0);

    // PULSE with default parameters
    q0 = bsyd;
    kick(3, 1'b1);
    for (int i = 0; i < 29800 && !bd.done; i++) @(negedge clk);
    #1;
    chk("dflt_done", bd.done, 1);
    chk("dflt_busy_cycles", bsyd - q0, 29699);
    chk("dflt_err", bd.err, 0);
    chk("dflt_shift_count", bd.shift_count, 29698);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/ccff_multi_loader.md
# ccff_multi_loader

Parametrised configuration-chain programmer for the FPGA fabric in the user project area. It drives NUM_CHAINS parallel configuration chains (ccff_head/ccff_tail) of CHAIN_LEN bits each, either streaming a bitstream from a valid/ready source (LOAD mode) or running a self-check (PULSE mode). In PULSE mode it injects a single '1' followed by zeros and verifies, per chain, that the pulse emerges at the tail exactly after CHAIN_LEN shifts. It sits between the SoC-side bitstream source (Wishbone/LA bridge or GPIO pins) and the fabric programming ports.

## Interface
- NUM_CHAINS, default 1: number of parallel configuration chains.
- CHAIN_LEN, default 29696: flip-flops per chain; must be ≥ 2.
- CNT_W, default $clog2(CHAIN_LEN+3): width of the shift counter.
- prog_clk  in  1: programming clock; all state on rising edge.
- RSTB  in  1: asynchronous active-low reset.
- start  in  1: one-cycle request; accepted only in IDLE or DONE.
- mode  in  1: 0 = LOAD, 1 = PULSE; sampled with start.
- s_data  in  NUM_CHAINS: one bitstream bit per chain, bit i to chain i.
- s_valid  in  1: s_data valid.
- s_ready  out  1: loader accepts s_data this cycle.
- ccff_head  out  NUM_CHAINS: registered serial data to chain heads.
- ccff_shift_en  out  1: registered; fabric shifts on the prog_clk edge where this is 1.
- ccff_tail  in  NUM_CHAINS: chain tails, synchronous to prog_clk.
- busy  out  1: state is SHIFT or CHECK.
- done  out  1: state is DONE.
- err  out  NUM_CHAINS: per-chain PULSE failure flags; valid while done.
- shift_count  out  CNT_W: number of shifts issued in the current run.

## Operation
- States: IDLE, SHIFT, CHECK, DONE.
- IDLE/DONE + start: latch mode, clear shift_count and err, go to SHIFT. start while busy is ignored.
- SHIFT, LOAD mode:
  - s_ready = 1 combinationally in SHIFT.
  - On a cycle with s_valid && s_ready: register ccff_head <= s_data and ccff_shift_en <= 1, and increment shift_count. Otherwise ccff_shift_en <= 0 and ccff_head holds.
  - When the CHAIN_LEN-th word is accepted, go to DONE. err stays 0.
- SHIFT, PULSE mode:
  - s_ready = 0.
  - Issue one shift every cycle. ccff_head is all ones on shift 1 and all zeros afterwards.
  - After shift CHAIN_LEN is issued, go to CHECK.
- CHECK (PULSE only):
  - Continue shifting zeros for 2 further shifts (CHAIN_LEN+1, CHAIN_LEN+2).
  - Sample ccff_tail one cycle after the fabric edges for shifts CHAIN_LEN, CHAIN_LEN+1 and CHAIN_LEN+2.
  - Required values: all ones, then zero, then zero.
  - Any mismatch on chain i sets err[i] (sticky).
  - After the third sample, go to DONE.
- DONE: ccff_shift_en = 0, ccff_head = 0. done = 1 until the next start.
- Reset (asynchronous, any time, including mid-shift):
  - State goes to IDLE.
  - ccff_head, ccff_shift_en, s_ready, busy, done, err and shift_count all go to 0.
  - A partially loaded chain is not recovered; software must restart the run.

## Timing
- Latency from start to the first ccff_shift_en high:
  - PULSE mode: 1 cycle.
  - LOAD mode: 1 cycle after the first accepted beat.
- PULSE run: busy for exactly CHAIN_LEN+3 cycles, then done asserts.
- LOAD run: CHAIN_LEN accepted beats, then done asserts on the cycle after the last fabric shift edge.
- s_valid may drop at any time; each stall cycle yields ccff_shift_en = 0. No beat is lost or duplicated.
- shift_count saturates at CHAIN_LEN+2 and never wraps.

## Structure
- Package ccff_loader_pkg:
  - state enum (IDLE, SHIFT, CHECK, DONE);
  - mode encoding (MODE_LOAD = 0, MODE_PULSE = 1);
  - the expected tail-pattern constant (1, 0, 0).
- Sub-module ccff_pulse_checker holds the per-chain sample/compare logic and sticky err. It is NUM_CHAINS wide and driven by a check-phase index (0..2) and a sample strobe.

## Test plan
- Bench: a behavioural NUM_CHAINS × CHAIN_LEN shift-register model connected to ccff_head/ccff_tail.
- PULSE, NUM_CHAINS = 1, CHAIN_LEN = 8 -> done after 11 busy cycles, err = 0, shift_count = 10.
- PULSE, NUM_CHAINS = 4, CHAIN_LEN = 16, chain 2 model made length 15 -> err = 4'b0100.
- LOAD, NUM_CHAINS = 2, CHAIN_LEN = 8, s_data pattern 0xA5/0x3C, s_valid randomly deasserted ~30% -> model contents equal the pattern, exactly 8 ccff_shift_en pulses, done = 1.
- RSTB low during shift 5 of a PULSE run -> all outputs 0 immediately; a new start then completes with err = 0.
- start asserted while busy -> ignored, run completes unchanged. start in DONE -> err cleared and a new run begins.
- Default parameters (CHAIN_LEN = 29696), PULSE mode -> done after 29699 busy cycles, err = 0.
